pendulum_rwd_accum: RTL
=======================

Name: pendulum_rwd_accum

Overview:
Consumer end of the Pendulum reward interface. It accepts one float32 cost per environment step from the reward-compute stage and accumulates the episode return, return = -(sum of costs), in float32. It counts steps and flags episode completion at MAX_STEPS. It applies backpressure to the reward stage while its multi-cycle adder is busy.

Parameters:
MAX_STEPS, 200, episode length in accepted rewards
CNT_W, 8, width of step counter; must satisfy 2^CNT_W > MAX_STEPS

Ports:
i_clk  in  1  clock, all logic on rising edge
i_rst_n  in  1  synchronous active-low reset
i_clr  in  1  start new episode: clears return, step count and done
i_rwd_valid  in  1  cost word valid; held with i_rwd stable until accepted
i_rwd  in  32  IEEE-754 single cost, expected >= 0
o_rwd_ready  out  1  block can accept a cost this cycle
o_ret  out  32  accumulated return, float32, always <= 0
o_ret_valid  out  1  one-cycle pulse when o_ret has just updated
o_step_cnt  out  CNT_W  rewards accepted this episode
o_done  out  1  level, high once o_step_cnt == MAX_STEPS

Behaviour:
- Reset (i_rst_n=0 at clock edge): o_ret=32'h00000000, o_ret_valid=0, o_step_cnt=0, o_done=0, FSM=IDLE, o_rwd_ready=1 on the next cycle.
- Priority: reset > i_clr > handshake. i_clr produces the same register values as reset and aborts any in-flight add; that add never updates o_ret or pulses o_ret_valid.
- Handshake: accept when i_rwd_valid && o_rwd_ready at a rising edge. o_rwd_ready = (state==IDLE) && !o_done.
- Capture at accept. Capture i_rwd into an operand register and increment o_step_cnt at that edge. Set o_done at the same edge when the new count equals MAX_STEPS.
- FSM: IDLE -> ALIGN -> ADD -> NORM -> WRITE -> IDLE, one cycle per state, no stalls.
  - ALIGN: compare exponents, right-shift the smaller mantissa, keep guard/round/sticky bits.
  - ADD: 25-bit magnitude add.
  - NORM: 1-bit right shift on carry, exponent increment, round-to-nearest-even.
  - WRITE: register result into o_ret and pulse o_ret_valid.
- Latency: handshake at edge N gives updated o_ret and o_ret_valid=1 during the cycle after edge N+4. Throughput is 1 reward per 5 cycles. o_rwd_ready is high again in the cycle o_ret_valid pulses.
- Arithmetic is a magnitude add only. The running magnitude M starts at +0, M' = round(M + |i_rwd|), and o_ret = {1'b1, M[30:0]}. The exception is M == 0, where o_ret = 32'h00000000.
- Input sign bit is ignored (treated as |x|).
- Denormal input (exp==0) is treated as zero. There are no denormal results.
- Overflow, meaning the exponent reaches 255 after normalisation or rounding, gives M = +Inf and o_ret = 32'hFF800000. Inf is sticky until i_clr or reset.
- NaN input (exp==255, mant!=0) forces o_ret = 32'hFFC00000, sticky until i_clr or reset.
- Exponent difference > 25 leaves the larger operand unchanged; the smaller contributes sticky only.
- When o_done=1, o_rwd_ready=0 and further valids are left pending, not dropped. o_step_cnt never exceeds MAX_STEPS.
- i_clr in the same cycle as a valid: clear wins and the cost is not accepted. The upstream keeps it held and it is accepted at the next IDLE edge.

Test Plan:
1. Reset, then three costs 1.0 (3F800000), 2.0 (40000000), 0.5 (3F000000), valid held. Required: three o_ret_valid pulses, 5 cycles apart, with o_ret = BF800000, C0400000, C0600000; o_step_cnt = 3; first pulse in the cycle after edge N+4.
2. Accumulated magnitude 2^24 (4B800000), then add 1.0. Required: o_ret = CB800000 (tie to even). Then add 3.0: o_ret = CB800002.
3. Two costs of 7F7FFFFF. Required: o_ret = FF800000. A further add of 1.0 keeps FF800000. i_clr gives 00000000.
4. MAX_STEPS=4, six costs of 1.0 offered back-to-back. Required: o_done rises at the 4th accept; o_ret = C0800000; o_rwd_ready stays 0; o_step_cnt holds 4; valid stays pending. Pulse i_clr: the 5th cost is accepted, o_ret = BF800000.
5. i_clr asserted two cycles after accepting 4.0. Required: no o_ret_valid pulse; o_ret = 00000000, o_step_cnt = 0. i_rst_n low mid-add gives the same result. Denormal input 00000001 leaves o_ret unchanged but increments o_step_cnt.
6. Input with sign set, BF800000. Required: treated as 1.0, o_ret = BF800000. Then input 7FC00001: o_ret = FFC00000.

Source files
------------

// File: rtl/pendulum_rwd_accum.sv
// Purpose: accumulates episode return = -(sum of float32 costs), counts steps, flags episode end.
// Latency: accept at edge N -> o_ret/o_ret_valid updated in the cycle after edge N+4; one cost per 5 cycles.
// Backpressure: o_rwd_ready low while the adder is busy or the episode is done; pending costs are held upstream.
//
// Ports:
//   i_clk, i_rst_n      clock (rising edge), synchronous active-low reset
//   i_clr               start a new episode (same effect as reset, aborts an in-flight add)
//   i_rwd_valid/i_rwd   float32 cost, sign ignored; o_rwd_ready accepts it
//   o_ret/o_ret_valid   accumulated return (always <= 0) and its one-cycle update pulse
//   o_step_cnt, o_done  costs accepted this episode, level high once MAX_STEPS reached
module pendulum_rwd_accum #(
    parameter int MAX_STEPS = 200,
    parameter int CNT_W     = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_rwd_valid,
    input  logic [31:0]      i_rwd,
    output logic             o_rwd_ready,
    output logic [31:0]      o_ret,
    output logic             o_ret_valid,
    output logic [CNT_W-1:0] o_step_cnt,
    output logic             o_done
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ALIGN = 3'd1;
    localparam logic [2:0] ST_ADD   = 3'd2;
    localparam logic [2:0] ST_NORM  = 3'd3;
    localparam logic [2:0] ST_WRITE = 3'd4;

    localparam logic [31:0] ABS_MASK = 32'h7FFF_FFFF;
    localparam logic [30:0] MAG_INF  = 31'h7F80_0000;

    logic [2:0]  state;
    logic [30:0] op_q;        // captured |cost|
    logic [30:0] mag_q;       // running magnitude M
    logic        inf_q;
    logic        nan_q;

    // pipeline registers between FSM states
    logic [26:0] big_q;       // larger mantissa with 3 guard/round/sticky bits
    logic [26:0] small_q;     // aligned smaller mantissa, sticky folded into bit 0
    logic [7:0]  exp_q;
    logic        op_inf_q;
    logic        op_nan_q;
    logic [27:0] sum_q;
    logic [30:0] res_q;
    logic        res_inf_q;
    logic        res_nan_q;

    assign o_rwd_ready = (state == ST_IDLE) && !o_done;

    // ---------------- alignment ----------------
    logic [7:0]  m_exp, x_exp, b_exp, s_exp, diff;
    logic [23:0] m_man, x_man, b_man, s_man;
    logic        m_big;
    logic [4:0]  shamt;
    logic [53:0] sh_full;
    logic [26:0] s_al;
    logic        op_nan, op_inf;

    assign m_exp = mag_q[30:23];
    assign x_exp = op_q[30:23];
    // exponent 0 (zero or denormal) contributes nothing
    assign m_man = (m_exp == 8'd0) ? 24'd0 : {1'b1, mag_q[22:0]};
    assign x_man = (x_exp == 8'd0) ? 24'd0 : {1'b1, op_q[22:0]};
    assign m_big = (m_exp >= x_exp);
    assign b_exp = m_big ? m_exp : x_exp;
    assign s_exp = m_big ? x_exp : m_exp;
    assign b_man = m_big ? m_man : x_man;
    assign s_man = m_big ? x_man : m_man;
    assign diff  = b_exp - s_exp;
    // a shift of 27 already pushes every bit into the sticky field
    assign shamt   = (diff > 8'd27) ? 5'd27 : diff[4:0];
    assign sh_full = {s_man, 30'd0} >> shamt;
    assign s_al    = {sh_full[53:28], sh_full[27] | (|sh_full[26:0])};
    assign op_nan  = (x_exp == 8'hFF) && (op_q[22:0] != 23'd0);
    assign op_inf  = (x_exp == 8'hFF) && (op_q[22:0] == 23'd0);

    // ---------------- normalise and round ----------------
    logic [26:0] n_m;
    logic [8:0]  n_e, f_e;
    logic        rnd_up, ovf;
    logic [24:0] r_man;
    logic [22:0] f_man;

    // magnitude-only add: at most one bit of growth, never a left shift
    assign n_m    = sum_q[27] ? {sum_q[27:2], sum_q[1] | sum_q[0]} : sum_q[26:0];
    assign n_e    = {1'b0, exp_q} + 9'(sum_q[27]);
    assign rnd_up = n_m[2] & (n_m[1] | n_m[0] | n_m[3]);
    assign r_man  = {1'b0, n_m[26:3]} + 25'(rnd_up);
    // rounding carry-out leaves mantissa 1.000..., only the exponent moves
    assign f_e    = n_e + 9'(r_man[24]);
    assign f_man  = r_man[24] ? r_man[23:1] : r_man[22:0];
    assign ovf    = (f_e >= 9'd255);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clr) begin
            state       <= ST_IDLE;
            op_q        <= '0;
            mag_q       <= '0;
            inf_q       <= 1'b0;
            nan_q       <= 1'b0;
            big_q       <= '0;
            small_q     <= '0;
            exp_q       <= '0;
            op_inf_q    <= 1'b0;
            op_nan_q    <= 1'b0;
            sum_q       <= '0;
            res_q       <= '0;
            res_inf_q   <= 1'b0;
            res_nan_q   <= 1'b0;
            o_ret       <= 32'h0000_0000;
            o_ret_valid <= 1'b0;
            o_step_cnt  <= '0;
            o_done      <= 1'b0;
        end else begin
            o_ret_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_rwd_valid && o_rwd_ready) begin
                        op_q       <= 31'(i_rwd & ABS_MASK);  // sign dropped here
                        o_step_cnt <= o_step_cnt + CNT_W'(1);
                        o_done     <= ((o_step_cnt + CNT_W'(1)) == CNT_W'(MAX_STEPS));
                        state      <= ST_ALIGN;
                    end
                end
                ST_ALIGN: begin
                    big_q    <= {b_man, 3'b000};
                    small_q  <= s_al;
                    exp_q    <= b_exp;
                    op_inf_q <= op_inf;
                    op_nan_q <= op_nan;
                    state    <= ST_ADD;
                end
                ST_ADD: begin
                    sum_q <= {1'b0, big_q} + {1'b0, small_q};
                    state <= ST_NORM;
                end
                ST_NORM: begin
                    res_inf_q <= inf_q | op_inf_q | ovf;
                    res_nan_q <= nan_q | op_nan_q;
                    res_q     <= (inf_q | op_inf_q | ovf) ? MAG_INF : {f_e[7:0], f_man};
                    state     <= ST_WRITE;
                end
                ST_WRITE: begin
                    mag_q       <= res_q;
                    inf_q       <= res_inf_q;
                    nan_q       <= res_nan_q;
                    o_ret       <= res_nan_q        ? 32'hFFC0_0000 :
                                   res_inf_q        ? 32'hFF80_0000 :
                                   (res_q == '0)    ? 32'h0000_0000 : {1'b1, res_q};
                    o_ret_valid <= 1'b1;
                    state       <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
